// File: rtl/gpu_cmd_pkg.sv
// Shared definitions for the GPU command decoder: opcodes, payload lengths,
// decoder states and a small helper for x high-byte positions.
package gpu_cmd_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_FILL = 8'h10;
    localparam logic [7:0] OP_BLIT = 8'h20;

    localparam int FILL_LEN = 7;
    localparam int BLIT_LEN = 9;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PAYLOAD = 3'd1,
        S_PENDING = 3'd2,
        S_ISSUE   = 3'd3,
        S_ACK     = 3'd4
    } state_t;

    // Payload byte positions holding an x high byte (X1 hi, X2 hi, W hi on BLIT).
    function automatic logic is_x_high(input logic [3:0] idx, input logic blit);
        return (idx == 4'd1) || (idx == 4'd4) || (blit && (idx == 4'd7));
    endfunction

endpackage

// File: rtl/gpu_cmd_assembler.sv
// Payload assembler: byte counter plus shadow register file. The shadow is
// written as bytes arrive; the top copies it to the outputs only at issue.
import gpu_cmd_pkg::*;

module gpu_cmd_assembler #(
    parameter int XW = 9,
    parameter int YW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_op,         // opcode of a FILL/BLIT accepted
    input  logic          op_blit,         // opcode kind at load_op
    input  logic          shift_en,        // payload byte accepted
    input  logic [7:0]    data,
    output logic          frame_complete,  // last payload byte, well formed
    output logic          frame_malformed, // x high byte with bits 7:1 set
    output logic          sh_blit,
    output logic [XW-1:0] sh_x1,
    output logic [XW-1:0] sh_x2,
    output logic [XW-1:0] sh_bw,
    output logic [YW-1:0] sh_y1,
    output logic [YW-1:0] sh_y2,
    output logic [YW-1:0] sh_bh,
    output logic          sh_val
);

    logic [3:0] idx;
    logic [3:0] last_idx;

    assign last_idx        = sh_blit ? 4'(BLIT_LEN - 1) : 4'(FILL_LEN - 1);
    assign frame_malformed = shift_en && is_x_high(idx, sh_blit) && (data[7:1] != 7'd0);
    assign frame_complete  = shift_en && (idx == last_idx) && !frame_malformed;

    // Byte counter and frame kind; counter restarts on every opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= 4'd0;
            sh_blit <= 1'b0;
        end else if (load_op) begin
            idx     <= 4'd0;
            sh_blit <= op_blit;
        end else if (shift_en) begin
            idx <= idx + 4'd1;
        end
    end

    // Shadow register file: each payload position lands in its field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_x1  <= '0;
            sh_x2  <= '0;
            sh_bw  <= '0;
            sh_y1  <= '0;
            sh_y2  <= '0;
            sh_bh  <= '0;
            sh_val <= 1'b0;
        end else if (shift_en) begin
            case (idx)
                4'd0: sh_x1 <= XW'(data);
                4'd1: sh_x1 <= XW'({data[0], sh_x1[7:0]});
                4'd2: sh_y1 <= YW'(data);
                4'd3: sh_x2 <= XW'(data);
                4'd4: sh_x2 <= XW'({data[0], sh_x2[7:0]});
                4'd5: sh_y2 <= YW'(data);
                4'd6: begin
                    if (sh_blit) sh_bw  <= XW'(data);
                    else         sh_val <= data[0];
                end
                4'd7: sh_bw <= XW'({data[0], sh_bw[7:0]});
                4'd8: sh_bh <= YW'(data);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/gpu_command_decoder.sv
// Byte-stream command front end for the GPU operation engine. Assembles
// FILL/BLIT frames into a shadow, issues them with a one-cycle start pulse
// once the engine is idle, and counts accepted/rejected commands.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready;
// in_valid may be held with in_ready low and no byte is consumed.
import gpu_cmd_pkg::*;

module gpu_command_decoder #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 200
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       gpu_busy,
    input  logic                       gpu_error,
    output logic [$clog2(WIDTH)-1:0]   X1,
    output logic [$clog2(WIDTH)-1:0]   X2,
    output logic [$clog2(HEIGHT)-1:0]  Y1,
    output logic [$clog2(HEIGHT)-1:0]  Y2,
    output logic                       start_fill,
    output logic                       start_blit,
    output logic                       fill_value,
    output logic [$clog2(WIDTH)-1:0]   blit_x_width,
    output logic [$clog2(HEIGHT)-1:0]  blit_y_height,
    output logic                       bad_frame,
    output logic [7:0]                 cmd_done,
    output logic [7:0]                 cmd_rejected,
    output state_t                     dbg_state
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    state_t          state, state_next;
    logic            busy_q;
    logic            accept;
    logic            load_op;
    logic            bad_op;
    logic            shift_en;
    logic            issue;
    logic            frame_complete;
    logic            frame_malformed;
    logic            sh_blit;
    logic [XW-1:0]   sh_x1, sh_x2, sh_bw;
    logic [YW-1:0]   sh_y1, sh_y2, sh_bh;
    logic            sh_val;

    // in_ready is forced low while reset is asserted.
    assign in_ready  = rst_n && ((state == S_IDLE) || (state == S_PAYLOAD));
    assign accept    = in_valid && in_ready;
    assign shift_en  = accept && (state == S_PAYLOAD);
    // busy is registered so the engine's busy falling edge is seen one cycle
    // later; an idle engine still gives issue one cycle after the last byte.
    assign issue     = (state == S_PENDING) && !busy_q;
    assign dbg_state = state;

    gpu_cmd_assembler #(.XW(XW), .YW(YW)) u_asm (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_op         (load_op),
        .op_blit         (in_data == OP_BLIT),
        .shift_en        (shift_en),
        .data            (in_data),
        .frame_complete  (frame_complete),
        .frame_malformed (frame_malformed),
        .sh_blit         (sh_blit),
        .sh_x1           (sh_x1),
        .sh_x2           (sh_x2),
        .sh_bw           (sh_bw),
        .sh_y1           (sh_y1),
        .sh_y2           (sh_y2),
        .sh_bh           (sh_bh),
        .sh_val          (sh_val)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic and opcode decode.
    always_comb begin
        state_next = state;
        load_op    = 1'b0;
        bad_op     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if ((in_data == OP_FILL) || (in_data == OP_BLIT)) begin
                        load_op    = 1'b1;
                        state_next = S_PAYLOAD;
                    end else if (in_data != OP_NOP) begin
                        bad_op = 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (frame_malformed)     state_next = S_IDLE;
                else if (frame_complete) state_next = S_PENDING;
            end
            S_PENDING: if (issue) state_next = S_ISSUE;
            S_ISSUE:   state_next = S_ACK;
            S_ACK:     state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Engine busy sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= 1'b0;
        else        busy_q <= gpu_busy;
    end

    // Output registers load on entry to ISSUE; start pulse covers ISSUE only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            X1            <= '0;
            X2            <= '0;
            Y1            <= '0;
            Y2            <= '0;
            fill_value    <= 1'b0;
            blit_x_width  <= '0;
            blit_y_height <= '0;
            start_fill    <= 1'b0;
            start_blit    <= 1'b0;
        end else begin
            start_fill <= issue && !sh_blit;
            start_blit <= issue && sh_blit;
            if (issue) begin
                X1 <= sh_x1;
                X2 <= sh_x2;
                Y1 <= sh_y1;
                Y2 <= sh_y2;
                if (sh_blit) begin
                    blit_x_width  <= sh_bw;
                    blit_y_height <= sh_bh;
                end else begin
                    fill_value <= sh_val;
                end
            end
        end
    end

    // Bad-frame pulse and engine response counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_frame    <= 1'b0;
            cmd_done     <= 8'd0;
            cmd_rejected <= 8'd0;
        end else begin
            bad_frame <= bad_op || frame_malformed;
            if (state == S_ACK) begin
                if (gpu_error) cmd_rejected <= cmd_rejected + 8'd1;
                else           cmd_done     <= cmd_done + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_gpu_command_decoder.sv
// Bench for gpu_command_decoder: directed steps from the test plan followed by
// randomized frames, checked against a frame-level model and engine model.
import gpu_cmd_pkg::*;

module tb_gpu_command_decoder;

    localparam int W = 53;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        gpu_busy;
    logic        gpu_error;
    logic [8:0]  X1, X2, blit_x_width;
    logic [7:0]  Y1, Y2, blit_y_height;
    logic        start_fill, start_blit, fill_value, bad_frame;
    logic [7:0]  cmd_done, cmd_rejected;
    state_t      dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic [7:0]   exp_done = 8'd0;
    logic [7:0]   exp_rej  = 8'd0;
    int           exp_bad  = 0;
    int           bad_seen = 0;
    int           eng_len  = 3;
    bit           eng_active = 0;

    gpu_command_decoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .gpu_busy      (gpu_busy),
        .gpu_error     (gpu_error),
        .X1            (X1),
        .X2            (X2),
        .Y1            (Y1),
        .Y2            (Y2),
        .start_fill    (start_fill),
        .start_blit    (start_blit),
        .fill_value    (fill_value),
        .blit_x_width  (blit_x_width),
        .blit_y_height (blit_y_height),
        .bad_frame     (bad_frame),
        .cmd_done      (cmd_done),
        .cmd_rejected  (cmd_rejected),
        .dbg_state     (dbg_state)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // global time bound
    initial begin
        #500000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input bit blit, input logic [8:0] x1, input logic [7:0] y1,
                                          input logic [8:0] x2, input logic [7:0] y2, input logic val,
                                          input logic [8:0] bw, input logic [7:0] bh);
        if (blit) return {1'b1, x1, y1, x2, y2, 1'b0, bw, bh};
        else      return {1'b0, x1, y1, x2, y2, val, 9'd0, 8'd0};
    endfunction

    // engine model: starts on a pulse; rejects inverted rectangles, else busy for eng_len cycles
    initial begin
        bit err;
        gpu_busy  = 1'b0;
        gpu_error = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && (start_fill || start_blit)) begin
                eng_active = 1;
                err = (X1 > X2) || (Y1 > Y2);
                @(posedge clk); #1;
                if (err) begin
                    gpu_error = 1'b1;
                    @(posedge clk); #1;
                    gpu_error = 1'b0;
                end else begin
                    gpu_busy = 1'b1;
                    repeat (eng_len) @(posedge clk);
                    #1;
                    gpu_busy = 1'b0;
                end
                eng_active = 0;
            end
        end
    end

    // scoreboard monitor: every start pulse must match the next expected frame
    initial begin
        logic prev_start, prev_bad;
        logic [W-1:0] obs, e;
        prev_start = 1'b0;
        prev_bad   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_start) check("start_one_cycle", {start_fill, start_blit}, 2'b00);
                if (prev_bad)   check("bad_one_cycle", bad_frame, 1'b0);
                if (start_fill || start_blit) begin
                    check("start_exclusive", start_fill & start_blit, 1'b0);
                    obs = pack(start_blit, X1, Y1, X2, Y2, fill_value, blit_x_width, blit_y_height);
                    e   = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                    check("issue_fields", obs, e);
                end
                if (bad_frame) bad_seen++;
                prev_start = start_fill || start_blit;
                prev_bad   = bad_frame;
            end else begin
                prev_start = 1'b0;
                prev_bad   = 1'b0;
            end
        end
    end

    // driver tasks (called aligned to posedge + 1)
    task automatic idle(input int k);
        in_valid = 1'b0;
        repeat (k) begin
            in_data = 8'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check("byte_accept", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit blit, input logic [8:0] x1, input logic [7:0] y1,
                              input logic [8:0] x2, input logic [7:0] y2, input logic val,
                              input logic [8:0] bw, input logic [7:0] bh, input int gap_max);
        logic [7:0] b[$];
        b.push_back(blit ? OP_BLIT : OP_FILL);
        b.push_back(x1[7:0]); b.push_back({7'd0, x1[8]}); b.push_back(y1);
        b.push_back(x2[7:0]); b.push_back({7'd0, x2[8]}); b.push_back(y2);
        if (blit) begin
            b.push_back(bw[7:0]); b.push_back({7'd0, bw[8]}); b.push_back(bh);
        end else begin
            b.push_back({7'd0, val});
        end
        exp_q.push_back(pack(blit, x1, y1, x2, y2, val, bw, bh));
        if ((x1 > x2) || (y1 > y2)) exp_rej++;
        else                        exp_done++;
        @(posedge clk); #1;
        foreach (b[i]) begin
            idle($urandom_range(0, gap_max));
            send_byte(b[i]);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || eng_active || dbg_state != S_IDLE) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check("drain_in_time", n < 3000, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_done"}, cmd_done, exp_done);
        check({tag, "_rejected"}, cmd_rejected, exp_rej);
    endtask

    // directed and random sequence
    initial begin
        bit blit;
        logic [8:0] x1, x2, bw;
        logic [7:0] y1, y2, bh;
        logic val;
        int n;

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_x1", X1, 9'd0);
        check("rst_start", {start_fill, start_blit}, 2'b00);
        check("rst_counters", {cmd_done, cmd_rejected}, 16'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1'b1);

        // FILL 0x10 05 00 0A 40 01 14 01 with the engine idle
        send_frame(0, 9'd5, 8'd10, 9'd320, 8'd20, 1'b1, 9'd0, 8'd0, 0);
        @(negedge clk);
        check("fill_n_start", start_fill, 1'b0);
        check("fill_n_ready", in_ready, 1'b0);
        @(negedge clk);
        check("fill_n1_start", start_fill, 1'b1);
        check("fill_x1", X1, 9'd5);
        check("fill_y1", Y1, 8'd10);
        check("fill_x2", X2, 9'd320);
        check("fill_y2", Y2, 8'd20);
        check("fill_value", fill_value, 1'b1);
        @(negedge clk);
        check("fill_n2_ready", in_ready, 1'b0);
        @(negedge clk);
        check("fill_n3_ready", in_ready, 1'b1);
        n = 0;
        while (!gpu_busy && n < 20) begin n++; @(negedge clk); end
        check("fill_engine_busy", gpu_busy, 1'b1);
        check("fill_cmd_done", cmd_done, 8'd1);
        drain();

        // BLIT with X1 > X2: engine rejects it
        send_frame(1, 9'd10, 8'd2, 9'd5, 8'd9, 1'b0, 9'd4, 8'd3, 0);
        drain();
        check("blit_rejected", cmd_rejected, 8'd1);
        check("blit_done_unchanged", cmd_done, 8'd1);
        check("blit_back_idle", in_ready, 1'b1);

        // second FILL streamed while the engine is busy for 100 cycles
        eng_len = 100;
        send_frame(0, 9'd3, 8'd4, 9'd100, 8'd50, 1'b0, 9'd0, 8'd0, 0);
        send_frame(0, 9'd7, 8'd8, 9'd200, 8'd99, 1'b1, 9'd0, 8'd0, 0);
        @(negedge clk);
        check("b2b_ready_low", in_ready, 1'b0);
        check("b2b_hold_x1", X1, 9'd3);
        check("b2b_hold_x2", X2, 9'd100);
        check("b2b_hold_y2", Y2, 8'd50);
        check("b2b_hold_val", fill_value, 1'b0);
        n = 0;
        while (gpu_busy && n < 300) begin n++; @(negedge clk); end
        check("b2b_busy_fell", gpu_busy, 1'b0);
        eng_len = 3;
        @(negedge clk);
        check("b2b_fall_plus1", start_fill, 1'b0);
        @(negedge clk);
        check("b2b_fall_plus2", start_fill, 1'b1);
        check("b2b_new_x1", X1, 9'd7);
        drain();
        check_counters("b2b");

        // unknown opcode, then a normal FILL
        @(posedge clk); #1;
        send_byte(8'h7F);
        exp_bad++;
        @(negedge clk);
        check("badop_pulse", bad_frame, 1'b1);
        check("badop_idle", in_ready, 1'b1);
        @(negedge clk);
        check("badop_pulse_end", bad_frame, 1'b0);
        send_frame(0, 9'd1, 8'd1, 9'd2, 8'd2, 1'b1, 9'd0, 8'd0, 0);
        drain();

        // malformed x high byte discards the frame
        @(posedge clk); #1;
        send_byte(OP_FILL); send_byte(8'h11); send_byte(8'h02);
        exp_bad++;
        @(negedge clk);
        check("malformed_pulse", bad_frame, 1'b1);
        check("malformed_idle", dbg_state, S_IDLE);
        @(negedge clk);
        check("malformed_pulse_end", bad_frame, 1'b0);
        check_counters("malformed");

        // reset after 4 BLIT payload bytes
        @(posedge clk); #1;
        send_byte(OP_BLIT); send_byte(8'h0C); send_byte(8'h00); send_byte(8'h03); send_byte(8'h28);
        rst_n = 1'b0;
        exp_done = 8'd0;
        exp_rej  = 8'd0;
        @(negedge clk);
        check("midrst_ready", in_ready, 1'b0);
        check("midrst_coords", {X1, Y1, X2, Y2}, 34'd0);
        check("midrst_misc", {fill_value, blit_x_width, blit_y_height, bad_frame}, 19'd0);
        check_counters("midrst");
        @(posedge clk); #1; rst_n = 1'b1;
        send_frame(1, 9'd12, 8'd3, 9'd40, 8'd30, 1'b0, 9'd29, 8'd28, 0);
        drain();
        check("fresh_bw", blit_x_width, 9'd29);
        check("fresh_bh", blit_y_height, 8'd28);
        check_counters("fresh");

        // random frames, each replayed with random gaps some of the time
        for (int f = 0; f < 24; f++) begin
            blit = 1'($urandom_range(0, 1));
            x1 = 9'($urandom_range(0, 319));
            y1 = 8'($urandom_range(0, 199));
            x2 = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 319)) : 9'($urandom_range(x1, 319));
            y2 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 199)) : 8'($urandom_range(y1, 199));
            val = 1'($urandom_range(0, 1));
            bw = 9'($urandom_range(0, 511));
            bh = 8'($urandom_range(0, 255));
            eng_len = $urandom_range(1, 6);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                send_byte(OP_NOP);
            end
            send_frame(blit, x1, y1, x2, y2, val, bw, bh, 0);
            if (f % 2 == 0) send_frame(blit, x1, y1, x2, y2, val, bw, bh, 4);
        end
        drain();
        check_counters("random");
        check("bad_pulse_count", bad_seen, exp_bad);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
